// File: rtl/uart_tx_if.sv
// Transmit-side bundle for the fixed-message UART: enable in, line and status out.
// Clock and reset stay outside as plain ports on the transmitter.
interface uart_tx_if;
    logic i_Tx_DV;
    logic clk2mhz;
    logic o_Tx_Active;
    logic o_Tx_Serial;
    logic o_Tx_Done;

    modport master (
        output i_Tx_DV,
        input  clk2mhz,
        input  o_Tx_Active,
        input  o_Tx_Serial,
        input  o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV,
        output clk2mhz,
        output o_Tx_Active,
        output o_Tx_Serial,
        output o_Tx_Done
    );
endinterface

// File: rtl/uart_tx.sv
// Fixed-message 8N1 UART transmitter: loops "Hello!\r\n" while enabled, with all
// bit timing derived from a divided 2 MHz tick that is also exported as clk2mhz.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 17,
    parameter int unsigned CLK_DIV      = 25,
    parameter int unsigned MSG_LEN      = 8
) (
    input  logic     i_Clock,
    input  logic     i_Rst_n,
    uart_tx_if.slave tx
);

    localparam int unsigned TickW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             clk2mhz_q;
    logic             tick;

    state_e           state_q;
    logic [CntW-1:0]  clk_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [IdxW-1:0]  msg_idx_q;
    logic [7:0]       shift_q;
    logic             serial_q;
    logic             active_q;
    logic             done_q;
    logic             bit_last;

    function automatic logic [7:0] msg_rom(input logic [IdxW-1:0] idx);
        logic [7:0] b;
        unique case (32'(idx))
            0:       b = 8'h48;
            1:       b = 8'h65;
            2:       b = 8'h6C;
            3:       b = 8'h6C;
            4:       b = 8'h6F;
            5:       b = 8'h21;
            6:       b = 8'h0D;
            7:       b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign tick     = (tick_cnt_q == TickW'(CLK_DIV - 1));
    assign bit_last = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    end

    // clk2mhz is derived from the next count so it lines up with tick_cnt itself.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tick_cnt_q <= '0;
            clk2mhz_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            clk2mhz_q  <= (32'(tick_cnt_d) >= (CLK_DIV / 2));
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            msg_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    StIdle: begin
                        serial_q <= 1'b1;
                        active_q <= 1'b0;
                        if (tx.i_Tx_DV) begin
                            shift_q   <= msg_rom(msg_idx_q);
                            clk_cnt_q <= '0;
                            bit_idx_q <= '0;
                            serial_q  <= 1'b0;
                            active_q  <= 1'b1;
                            state_q   <= StStart;
                        end
                    end
                    StStart: begin
                        if (bit_last) begin
                            clk_cnt_q <= '0;
                            serial_q  <= shift_q[0];
                            state_q   <= StData;
                        end else begin
                            clk_cnt_q <= clk_cnt_q + CntW'(1);
                        end
                    end
                    StData: begin
                        if (bit_last) begin
                            clk_cnt_q <= '0;
                            if (bit_idx_q != 3'd7) begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                                serial_q  <= shift_q[3'(bit_idx_q + 3'd1)];
                            end else begin
                                serial_q <= 1'b1;
                                state_q  <= StStop;
                            end
                        end else begin
                            clk_cnt_q <= clk_cnt_q + CntW'(1);
                        end
                    end
                    StStop: begin
                        if (bit_last) begin
                            clk_cnt_q <= '0;
                            done_q    <= 1'b1;
                            active_q  <= 1'b0;
                            msg_idx_q <= (msg_idx_q == IdxW'(MSG_LEN - 1)) ? '0
                                                                           : msg_idx_q + IdxW'(1);
                            state_q   <= StIdle;
                        end else begin
                            clk_cnt_q <= clk_cnt_q + CntW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign tx.clk2mhz     = clk2mhz_q;
    assign tx.o_Tx_Serial = serial_q;
    assign tx.o_Tx_Active = active_q;
    assign tx.o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: decodes the serial line against a message-sequence
// model and checks divider waveform, frame timing, Done/Active and reset behaviour.
module tb_uart_tx;

    localparam int CPB       = 17;
    localparam int DIV       = 25;
    localparam int LEN       = 8;
    localparam int BIT_CYC   = CPB * DIV;       // 425 clocks per UART bit
    localparam int FRAME_CYC = 10 * BIT_CYC;    // 4250 clocks per frame
    localparam int SLOT      = FRAME_CYC + DIV; // frame plus one-tick gap

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    int   exp_idx = 0;

    logic [7:0] rom [0:7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h0D, 8'h0A};

    uart_tx_if bus ();

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .CLK_DIV     (DIV),
        .MSG_LEN     (LEN)
    ) dut (
        .i_Clock(clk),
        .i_Rst_n(rst_n),
        .tx     (bus)
    );

    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: the byte that the next completed frame must carry.
    function automatic logic [7:0] next_expected();
        logic [7:0] b;
        b       = rom[exp_idx];
        exp_idx = (exp_idx + 1) % LEN;
        return b;
    endfunction

    task automatic do_reset(input logic dv);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_Tx_DV = dv;
        exp_idx     = 0;
        rst_n       = 1'b1;
    endtask

    // Waits for a start edge, records one frame slot and decodes it mid-bit.
    task automatic capture_frame(input int drop_at, output int lead, output logic [7:0] data,
                                 output logic start_b, output logic stop_b,
                                 output bit framing_ok, output int done_off,
                                 output int done_cnt, output bit active_ok);
        logic ln [0:SLOT-1];
        lead       = 0;
        data       = '0;
        start_b    = 1'bx;
        stop_b     = 1'bx;
        framing_ok = 1'b0;
        done_off   = -1;
        done_cnt   = 0;
        active_ok  = 1'b0;
        do begin
            cyc();
            lead++;
        end while (bus.o_Tx_Serial !== 1'b0 && lead < 20000);
        if (bus.o_Tx_Serial !== 1'b0) begin
            lead = -1;
            return;
        end
        framing_ok = 1'b1;
        active_ok  = 1'b1;
        for (int k = 0; k < SLOT; k++) begin
            if (k > 0) cyc();
            ln[k] = bus.o_Tx_Serial;
            if (bus.o_Tx_Done === 1'b1) begin
                if (done_off < 0) done_off = k;
                done_cnt++;
            end
            if (bus.o_Tx_Active !== 1'(k < FRAME_CYC)) active_ok = 1'b0;
            if (k == drop_at) bus.i_Tx_DV = 1'b0;
        end
        for (int b = 0; b < 10; b++) begin
            if (b == 0) start_b = ln[BIT_CYC / 2];
            else if (b == 9) stop_b = ln[b * BIT_CYC + BIT_CYC / 2];
            else data[b-1] = ln[b * BIT_CYC + BIT_CYC / 2];
        end
        for (int k = 0; k < SLOT; k++) begin
            if (k < FRAME_CYC) begin
                if (ln[k] !== ln[(k / BIT_CYC) * BIT_CYC + BIT_CYC / 2]) framing_ok = 1'b0;
            end else if (ln[k] !== 1'b1) begin
                framing_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        bus.i_Tx_DV = 1'b1;
        rst_n       = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            checks++;
            if ({bus.o_Tx_Serial, bus.o_Tx_Active, bus.o_Tx_Done, bus.clk2mhz} !== 4'b1000) begin
                fails++;
                $display("FAIL reset_hold cyc %0d: serial/active/done/clk2mhz=%b, expected 1000",
                         i, {bus.o_Tx_Serial, bus.o_Tx_Active, bus.o_Tx_Done, bus.clk2mhz});
            end
        end
    endtask

    task automatic test_divider();
        int lows, highs;
        do_reset(1'b0);
        lows  = 0;
        highs = 0;
        for (int k = 1; k <= 1000; k++) begin
            cyc();
            checks++;
            if (bus.clk2mhz !== 1'((k % DIV) >= (DIV / 2))) begin
                fails++;
                $display("FAIL clk2mhz k=%0d: got %b, expected %b", k, bus.clk2mhz,
                         1'((k % DIV) >= (DIV / 2)));
            end
            if (k > 25 && k <= 50) begin
                if (bus.clk2mhz === 1'b1) highs++;
                else lows++;
            end
            checks++;
            if (bus.o_Tx_Serial !== 1'b1 || bus.o_Tx_Active !== 1'b0) begin
                fails++;
                $display("FAIL idle_no_dv k=%0d: serial=%b active=%b, expected 1 0", k,
                         bus.o_Tx_Serial, bus.o_Tx_Active);
            end
        end
        checks++;
        if (lows != 12 || highs != 13) begin
            fails++;
            $display("FAIL clk2mhz_duty: low=%0d high=%0d, expected 12 13", lows, highs);
        end
    endtask

    task automatic test_first_frame();
        int lead, doff, dcnt;
        logic [7:0] d, e;
        logic sb, pb;
        bit fok, aok;
        do_reset(1'b1);
        capture_frame(-1, lead, d, sb, pb, fok, doff, dcnt, aok);
        e = next_expected();
        checks++;
        if (lead != 25) begin
            fails++;
            $display("FAIL first_start_lead: got %0d cycles, expected 25", lead);
        end
        checks++;
        if (d !== e || sb !== 1'b0 || pb !== 1'b1) begin
            fails++;
            $display("FAIL first_byte: got %h start=%b stop=%b, expected %h 0 1", d, sb, pb, e);
        end
        checks++;
        if (!fok) begin
            fails++;
            $display("FAIL first_bit_timing: got unstable bits, expected %0d-cycle bits", BIT_CYC);
        end
        checks++;
        if (doff != FRAME_CYC || dcnt != 1) begin
            fails++;
            $display("FAIL first_done: got offset %0d count %0d, expected %0d 1", doff, dcnt,
                     FRAME_CYC);
        end
        checks++;
        if (!aok) begin
            fails++;
            $display("FAIL first_active: got wrong active window, expected high %0d cycles",
                     FRAME_CYC);
        end
    endtask

    task automatic test_back_to_back();
        int lead, doff, dcnt;
        logic [7:0] d, e;
        logic sb, pb;
        bit fok, aok;
        for (int f = 1; f < 9; f++) begin
            capture_frame(-1, lead, d, sb, pb, fok, doff, dcnt, aok);
            e = next_expected();
            checks++;
            if (lead != 1) begin
                fails++;
                $display("FAIL b2b_gap frame %0d: got lead %0d, expected 1 (25-cycle gap)", f, lead);
            end
            checks++;
            if (d !== e || sb !== 1'b0 || pb !== 1'b1 || !fok) begin
                fails++;
                $display("FAIL b2b_byte frame %0d: got %h start=%b stop=%b ok=%0d, expected %h",
                         f, d, sb, pb, fok, e);
            end
            checks++;
            if (doff != FRAME_CYC || dcnt != 1 || !aok) begin
                fails++;
                $display("FAIL b2b_done frame %0d: got off %0d cnt %0d act %0d, expected %0d 1 1",
                         f, doff, dcnt, aok, FRAME_CYC);
            end
        end
    endtask

    task automatic test_dv_drop();
        int lead, doff, dcnt, lows;
        logic [7:0] d, e;
        logic sb, pb;
        bit fok, aok;
        do_reset(1'b1);
        capture_frame(4 * BIT_CYC + 200, lead, d, sb, pb, fok, doff, dcnt, aok);
        e = next_expected();
        checks++;
        if (d !== e || pb !== 1'b1 || !fok || doff != FRAME_CYC || dcnt != 1) begin
            fails++;
            $display("FAIL drop_byte0: got %h stop=%b ok=%0d done %0d/%0d, expected %h 1 1 %0d/1",
                     d, pb, fok, doff, dcnt, e, FRAME_CYC);
        end
        lows = 0;
        for (int i = 0; i < 500; i++) begin
            cyc();
            if (bus.o_Tx_Serial !== 1'b1 || bus.o_Tx_Active !== 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin
            fails++;
            $display("FAIL drop_idle: got %0d non-idle cycles, expected 0", lows);
        end
        bus.i_Tx_DV = 1'b1;
        capture_frame(-1, lead, d, sb, pb, fok, doff, dcnt, aok);
        e = next_expected();
        checks++;
        if (lead < 1 || lead > DIV || d !== e || !fok) begin
            fails++;
            $display("FAIL drop_resume: got lead %0d byte %h ok=%0d, expected lead<=%0d byte %h",
                     lead, d, fok, DIV, e);
        end
    endtask

    task automatic test_reset_mid();
        int lead, doff, dcnt, wait_c;
        logic [7:0] d, e;
        logic sb, pb;
        bit fok, aok;
        lead = 0;
        do begin
            cyc();
            lead++;
        end while (bus.o_Tx_Serial !== 1'b0 && lead < 100);
        checks++;
        if (bus.o_Tx_Serial !== 1'b0) begin
            fails++;
            $display("FAIL mid_byte2_start: got no start bit in %0d cycles, expected one", lead);
        end
        wait_c = $urandom_range(50, FRAME_CYC - 100);
        repeat (wait_c) cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_Tx_Serial !== 1'b1 || bus.o_Tx_Active !== 1'b0 || bus.o_Tx_Done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_abort at %0d: serial=%b active=%b done=%b, expected 1 0 0",
                     wait_c, bus.o_Tx_Serial, bus.o_Tx_Active, bus.o_Tx_Done);
        end
        exp_idx = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        capture_frame(-1, lead, d, sb, pb, fok, doff, dcnt, aok);
        e = next_expected();
        checks++;
        if (lead != 25 || d !== e || !fok) begin
            fails++;
            $display("FAIL mid_reset_restart: got lead %0d byte %h ok=%0d, expected 25 %h 1",
                     lead, d, fok, e);
        end
    endtask

    task automatic test_random();
        int lead, doff, dcnt, lows, gap, drop;
        logic [7:0] d, e;
        logic sb, pb;
        bit fok, aok;
        for (int it = 0; it < 2; it++) begin
            bus.i_Tx_DV = 1'b1;
            drop = $urandom_range(1, FRAME_CYC - 1);
            capture_frame(drop, lead, d, sb, pb, fok, doff, dcnt, aok);
            e = next_expected();
            checks++;
            if (lead < 1 || lead > DIV || d !== e || !fok || doff != FRAME_CYC || dcnt != 1) begin
                fails++;
                $display("FAIL rand_frame it%0d drop@%0d: got lead %0d byte %h ok=%0d done %0d/%0d, expected %h",
                         it, drop, lead, d, fok, doff, dcnt, e);
            end
            gap  = $urandom_range(30, 400);
            lows = 0;
            for (int i = 0; i < gap; i++) begin
                cyc();
                if (bus.o_Tx_Serial !== 1'b1) lows++;
            end
            checks++;
            if (lows != 0) begin
                fails++;
                $display("FAIL rand_idle it%0d: got %0d low cycles, expected 0", it, lows);
            end
        end
    endtask

    initial begin
        bus.i_Tx_DV = 1'b0;
        test_reset();
        test_divider();
        test_first_frame();
        test_back_to_back();
        test_dv_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
